// File: rtl/ksa_byte_chain_arbiter.sv
// ksa_byte_chain_arbiter: two-requester round-robin front end that chains
// byte-serial add/sub transactions through one 8-bit Kogge-Stone adder.

module ksa_byte_chain_arbiter_ksa (
  input  logic [7:0] a,
  input  logic [7:0] b,
  input  logic       cin,
  output logic [7:0] sum,
  output logic       cout
);
  logic [7:0] p0;
  logic [7:0] g0;
  logic [7:0] g1;
  logic [7:2] p1;
  logic [7:0] g2;
  logic [7:0] g3;

  assign p0 = a ^ b;
  // cin is folded into bit 0 so every prefix group reaches it
  assign g0 = (a & b) | {7'b0, p0[0] & cin};

  for (genvar i = 0; i < 8; i++) begin : g_lv1
    if (i >= 1) begin : g_c
      assign g1[i] = g0[i] | (p0[i] & g0[i-1]);
    end else begin : g_p
      assign g1[i] = g0[i];
    end
    if (i >= 2) begin : g_pp
      assign p1[i] = p0[i] & p0[i-1];
    end
  end

  for (genvar i = 0; i < 8; i++) begin : g_lv2
    if (i >= 2) begin : g_c
      assign g2[i] = g1[i] | (p1[i] & g1[i-2]);
    end else begin : g_p
      assign g2[i] = g1[i];
    end
  end

  for (genvar i = 0; i < 8; i++) begin : g_lv3
    if (i >= 4) begin : g_c
      assign g3[i] = g2[i] | (p1[i] & p1[i-2] & g2[i-4]);
    end else begin : g_p
      assign g3[i] = g2[i];
    end
  end

  assign sum  = p0 ^ {g3[6:0], cin};
  assign cout = g3[7];
endmodule

module ksa_byte_chain_arbiter #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [1:0]         req_valid,
  output logic [1:0]         req_ready,
  input  logic [1:0]         req_last,
  input  logic [1:0]         req_sub,
  input  logic [2*WIDTH-1:0] req_a,
  input  logic [2*WIDTH-1:0] req_b,
  output logic               res_valid,
  input  logic               res_ready,
  output logic [WIDTH-1:0]   res_sum,
  output logic               res_id,
  output logic               res_last,
  output logic               res_cout,
  output logic               busy
);
  typedef enum logic {IDLE, BUSY} state_t;

  state_t     state;
  state_t     state_nx;
  logic       owner;
  logic       rr;
  logic       first;
  logic       mode;
  logic       carry;
  logic       win;
  logic       slot_free;
  logic       acc;
  logic [7:0] op_a;
  logic [7:0] op_b;
  logic       op_sub;
  logic       op_last;
  logic       eff_sub;
  logic       cin;
  logic [7:0] sum;
  logic       cout;

  assign win       = (&req_valid) ? rr : req_valid[1];
  assign slot_free = !res_valid || res_ready;
  assign acc       = (state == BUSY) && req_valid[owner] && slot_free;
  assign op_a      = owner ? req_a[15:8] : req_a[7:0];
  assign op_b      = owner ? req_b[15:8] : req_b[7:0];
  assign op_sub    = req_sub[owner];
  assign op_last   = req_last[owner];
  assign eff_sub   = first ? op_sub : mode;
  assign cin       = first ? op_sub : carry;
  assign busy      = (state == BUSY);

  ksa_byte_chain_arbiter_ksa u_ksa (
    .a   (op_a),
    .b   (eff_sub ? ~op_b : op_b),
    .cin (cin),
    .sum (sum),
    .cout(cout)
  );

  // Grant state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // Grant on any request, release on the last-byte accept
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: if (|req_valid) state_nx = BUSY;
      BUSY: if (acc && op_last) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Only the owner sees ready, and only when the slot can take a byte
  always_comb begin
    req_ready = 2'b00;
    if (state == BUSY) req_ready[owner] = slot_free;
  end

  // Owner, fairness pointer and carry chain state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      owner <= 1'b0;
      rr    <= 1'b0;
      first <= 1'b0;
      mode  <= 1'b0;
      carry <= 1'b0;
    end else begin
      if (state == IDLE && |req_valid) begin
        owner <= win;
        first <= 1'b1;
      end
      if (acc) begin
        first <= 1'b0;
        carry <= cout;
        if (first)   mode <= op_sub;
        if (op_last) rr   <= ~owner;
      end
    end
  end

  // Single result slot; a same-cycle accept overwrites a draining result
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      res_valid <= 1'b0;
      res_sum   <= '0;
      res_id    <= 1'b0;
      res_last  <= 1'b0;
      res_cout  <= 1'b0;
    end else if (acc) begin
      res_valid <= 1'b1;
      res_sum   <= sum;
      res_id    <= owner;
      res_last  <= op_last;
      res_cout  <= cout;
    end else if (res_ready) begin
      res_valid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_ksa_byte_chain_arbiter.sv
// tb_ksa_byte_chain_arbiter: directed and randomized checks of the arbiter
// against a whole-number transaction model and a per-requester scoreboard.

module tb_ksa_byte_chain_arbiter;
  logic        clk;
  logic        rst;
  logic [1:0]  req_valid;
  logic [1:0]  req_ready;
  logic [1:0]  req_last;
  logic [1:0]  req_sub;
  logic [15:0] req_a;
  logic [15:0] req_b;
  logic        res_valid;
  logic        res_ready;
  logic [7:0]  res_sum;
  logic        res_id;
  logic        res_last;
  logic        res_cout;
  logic        busy;

  typedef struct packed {
    logic [7:0] a;
    logic [7:0] b;
    logic       last;
    logic       sub;
  } in_t;

  typedef struct packed {
    logic       id;
    logic [7:0] sum;
    logic       cout;
    logic       last;
  } out_t;

  in_t  q_in[2][$];
  out_t q_exp[2][$];
  out_t log_q[$];
  int   acc_cyc[$];
  int   checks;
  int   errors;
  int   cyc;
  int   stall_pct;
  int   rdy_mode;
  logic [1:0] acc;

  ksa_byte_chain_arbiter #(.WIDTH(8)) dut (
    .clk      (clk),
    .rst      (rst),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_last (req_last),
    .req_sub  (req_sub),
    .req_a    (req_a),
    .req_b    (req_b),
    .res_valid(res_valid),
    .res_ready(res_ready),
    .res_sum  (res_sum),
    .res_id   (res_id),
    .res_last (res_last),
    .res_cout (res_cout),
    .busy     (busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Byte k of (A +/- B) over the low k+1 bytes, with the carry out of them
  function automatic logic [8:0] model_byte(bit sub, int k,
                                            logic [31:0] A, logic [31:0] B);
    logic [63:0] m;
    logic [63:0] al;
    logic [63:0] bl;
    logic [63:0] r;
    logic        c;
    m  = (64'd1 << (8 * (k + 1))) - 64'd1;
    al = {32'd0, A} & m;
    bl = {32'd0, B} & m;
    if (sub) begin
      r = al - bl;
      c = (al >= bl);
    end else begin
      r = al + bl;
      c = r[8 * (k + 1)];
    end
    return {c, r[8*k +: 8]};
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)",
               name, act, exp, cyc);
    end
  endtask

  task automatic add_txn(int id, bit sub, int n,
                         logic [31:0] A, logic [31:0] B);
    in_t  x;
    out_t e;
    logic [8:0] r;
    for (int k = 0; k < n; k++) begin
      x.a    = A[8*k +: 8];
      x.b    = B[8*k +: 8];
      x.last = (k == n - 1);
      x.sub  = (k == 0) ? sub : 1'($urandom);
      q_in[id].push_back(x);
      r      = model_byte(sub, k, A, B);
      e.id   = id[0];
      e.sum  = r[7:0];
      e.cout = r[8];
      e.last = (k == n - 1);
      q_exp[id].push_back(e);
    end
  endtask

  // Per-cycle protocol checks and scoreboard comparison of drained results
  task automatic compare();
    out_t got;
    out_t e;
    cyc++;
    if (rst) begin
      acc = 2'b00;
      return;
    end
    chk("ready_onehot", 32'($countones(req_ready) <= 1), 1);
    if (res_valid && !res_ready) chk("bp_ready_low", req_ready, 0);
    if (req_ready != 2'b00) chk("busy_with_ready", busy, 1);
    acc = req_valid & req_ready;
    if (acc != 2'b00) acc_cyc.push_back(cyc);
    if (res_valid && res_ready) begin
      got = {res_id, res_sum, res_cout, res_last};
      log_q.push_back(got);
      if (q_exp[res_id].size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_result: got %0h expected none", got);
      end else begin
        e = q_exp[res_id].pop_front();
        chk("sb_sum", res_sum, e.sum);
        chk("sb_cout", res_cout, e.cout);
        chk("sb_last", res_last, e.last);
      end
    end
  endtask

  task automatic drive();
    logic [1:0]  v;
    logic [1:0]  l;
    logic [1:0]  s;
    logic [15:0] a;
    logic [15:0] b;
    in_t         x;
    v = '0; l = '0; s = '0; a = '0; b = '0;
    for (int i = 0; i < 2; i++) begin
      if (acc[i] && q_in[i].size() > 0) void'(q_in[i].pop_front());
      if (q_in[i].size() > 0) begin
        x = q_in[i][0];
        v[i] = ($urandom_range(0, 99) >= stall_pct);
        l[i] = x.last;
        s[i] = x.sub;
        a[8*i +: 8] = x.a;
        b[8*i +: 8] = x.b;
      end
    end
    acc = 2'b00;
    req_valid = v;
    req_last  = l;
    req_sub   = s;
    req_a     = a;
    req_b     = b;
    if (rdy_mode == 0)      res_ready = 1'b1;
    else if (rdy_mode == 1) res_ready = ($urandom_range(0, 99) < 70);
    else                    res_ready = 1'b0;
  endtask

  task automatic tick();
    @(negedge clk);
    compare();
    @(posedge clk);
    #1;
    drive();
    #1;
  endtask

  task automatic run_done(int maxc, string name);
    int n;
    n = 0;
    while (!(q_in[0].size() == 0 && q_in[1].size() == 0 &&
             q_exp[0].size() == 0 && q_exp[1].size() == 0 &&
             !res_valid) && n < maxc) begin
      tick();
      n++;
    end
    chk(name, 32'(n < maxc), 1);
  endtask

  task automatic check_zero(string tag);
    chk({tag, "_req_ready"}, req_ready, 0);
    chk({tag, "_res_valid"}, res_valid, 0);
    chk({tag, "_res_sum"}, res_sum, 0);
    chk({tag, "_res_id"}, res_id, 0);
    chk({tag, "_res_last"}, res_last, 0);
    chk({tag, "_res_cout"}, res_cout, 0);
    chk({tag, "_busy"}, busy, 0);
  endtask

  initial begin
    int base;
    int base2;
    int n;
    checks = 0; errors = 0; cyc = 0;
    stall_pct = 0; rdy_mode = 0; acc = 2'b00;
    rst = 1'b1;
    req_valid = '0; req_last = '0; req_sub = '0;
    req_a = '0; req_b = '0; res_ready = 1'b1;

    chk("model_add_b0", model_byte(1'b0, 0, 32'h1FF, 32'h1), 9'h100);
    chk("model_add_b1", model_byte(1'b0, 1, 32'h1FF, 32'h1), 9'h002);
    chk("model_sub_b0", model_byte(1'b1, 0, 32'h100, 32'h1), 9'h0FF);
    chk("model_sub_b1", model_byte(1'b1, 1, 32'h100, 32'h1), 9'h100);

    // Reset with both requesters active
    add_txn(0, 1'b0, 2, 32'h01FF, 32'h0001);
    add_txn(1, 1'b1, 2, 32'h0100, 32'h0001);
    repeat (3) begin
      tick();
      check_zero("rst");
    end
    rst = 1'b0;
    #1;
    check_zero("post_rst");
    tick();
    chk("first_grant", req_ready, 2'b01);
    chk("first_busy", busy, 1);
    run_done(200, "t1_done");
    chk("t1_count", log_q.size(), 4);
    if (log_q.size() >= 4) begin
      chk("t1_r0", log_q[0], {1'b0, 8'h00, 1'b1, 1'b0});
      chk("t1_r1", log_q[1], {1'b0, 8'h02, 1'b0, 1'b1});
      chk("t1_r2", log_q[2], {1'b1, 8'hFF, 1'b0, 1'b0});
      chk("t1_r3", log_q[3], {1'b1, 8'h00, 1'b1, 1'b1});
    end

    // Contention: back-to-back single-byte transactions
    base = log_q.size();
    acc_cyc.delete();
    for (int j = 0; j < 3; j++) begin
      add_txn(0, 1'b0, 1, $urandom, $urandom);
      add_txn(1, 1'b0, 1, $urandom, $urandom);
    end
    run_done(200, "cont_done");
    chk("cont_count", log_q.size(), base + 6);
    if (log_q.size() >= base + 6) begin
      for (int j = 0; j < 6; j++)
        chk("cont_id", log_q[base + j].id, j % 2);
    end
    chk("cont_accepts", acc_cyc.size(), 6);
    if (acc_cyc.size() >= 6) begin
      for (int j = 1; j < 6; j++)
        chk("cont_gap", acc_cyc[j] - acc_cyc[j-1], 2);
    end

    // Single-byte subtract with borrow
    base = log_q.size();
    add_txn(1, 1'b1, 1, 32'h00, 32'h01);
    run_done(50, "sub1_done");
    if (log_q.size() > base)
      chk("sub1_res", log_q[base], {1'b1, 8'hFF, 1'b0, 1'b1});
    else
      chk("sub1_count", log_q.size(), base + 1);

    // Backpressure mid-transaction
    base = log_q.size();
    add_txn(0, 1'b0, 3, 32'h00FFFF, 32'h000001);
    rdy_mode = 2;
    n = 0;
    while (!res_valid && n < 20) begin
      tick();
      n++;
    end
    chk("bp_fill", res_valid, 1);
    for (int j = 0; j < 3; j++) begin
      chk("bp_req_ready", req_ready, 0);
      chk("bp_sum", res_sum, 8'h00);
      chk("bp_cout", res_cout, 1);
      tick();
    end
    rdy_mode = 0;
    run_done(100, "bp_done");
    chk("bp_count", log_q.size(), base + 3);
    if (log_q.size() >= base + 3) begin
      chk("bp_r0", log_q[base],     {1'b0, 8'h00, 1'b1, 1'b0});
      chk("bp_r1", log_q[base + 1], {1'b0, 8'h00, 1'b1, 1'b0});
      chk("bp_r2", log_q[base + 2], {1'b0, 8'h01, 1'b0, 1'b1});
    end

    // Reset in the middle of a transaction
    base = log_q.size();
    add_txn(0, 1'b0, 3, 32'h01FFFF, 32'h000001);
    n = 0;
    while (log_q.size() == base && n < 20) begin
      tick();
      n++;
    end
    chk("mr_first", log_q.size(), base + 1);
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      q_in[i].delete();
      q_exp[i].delete();
    end
    drive();
    #1;
    check_zero("mr_rst");
    tick();
    check_zero("mr_rst2");
    rst = 1'b0;
    #1;
    check_zero("mr_after");
    base2 = log_q.size();
    repeat (5) tick();
    chk("mr_no_more", log_q.size(), base2);
    chk("mr_idle_valid", res_valid, 0);
    add_txn(0, 1'b0, 1, 32'h10, 32'h20);
    run_done(50, "mr_new_done");
    if (log_q.size() > base2)
      chk("mr_new_res", log_q[base2], {1'b0, 8'h30, 1'b0, 1'b1});
    else
      chk("mr_new_count", log_q.size(), base2 + 1);

    // Randomized traffic with stalls and backpressure
    rdy_mode = 1;
    stall_pct = 25;
    for (int t = 0; t < 60; t++)
      add_txn(int'($urandom_range(0, 1)), 1'($urandom),
              int'($urandom_range(1, 4)), $urandom, $urandom);
    run_done(20000, "rand_done");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/ksa_byte_chain_arbiter.md
# ksa_byte_chain_arbiter

Round-robin arbiter and carry sequencer that shares one 8-bit Kogge-Stone adder datapath between two requesters. Each requester issues multi-byte add or subtract transactions one byte per handshake, least-significant byte first. The block chains the carry between bytes, locks the grant for the whole transaction, and returns per-byte results through a single registered output slot with backpressure. It sits between the operand sources and the 8-bit prefix adder, which it instantiates internally with an exposed carry-in.

## Interface
- WIDTH, 8, byte width of the operands and of the adder; only 8 is supported.
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  2  per-requester byte valid.
- req_ready  out  2  per-requester byte accept; at most one bit is set, and only for the owner.
- req_last  in  2  marks the most-significant (final) byte of the transaction.
- req_sub  in  2  1 = subtract (a - b); sampled on the first byte only.
- req_a  in  16  operand A byte; requester i uses bits [8i+7:8i].
- req_b  in  16  operand B byte; same packing as req_a.
- res_valid  out  1  result slot full.
- res_ready  in  1  consumer accepts the result.
- res_sum  out  8  sum or difference byte.
- res_id  out  1  requester that produced the result.
- res_last  out  1  result is the final byte of its transaction.
- res_cout  out  1  carry out of this byte; on a subtract, 1 = no borrow.
- busy  out  1  a grant is held.

## Operation
- **FSM, IDLE:** if any req_valid bit is set, grant it. If both are set, the requester at round-robin pointer rr wins. Latch the winner into owner, set first=1, go to BUSY. No byte is accepted in the IDLE cycle.
- **FSM, BUSY:** req_ready[owner] = !res_valid | res_ready. Non-owner ready = 0.
- **Byte accept:** an accept is req_valid[owner] & req_ready[owner].
- **Adder inputs:** on the first byte, mode <= req_sub[owner] and cin = req_sub[owner]. On later bytes, cin = the carry register. The B input is ~b when mode (or req_sub on the first byte) is 1, otherwise b.
- **On each accept:**
  - res_sum <= adder sum; res_cout <= adder cout.
  - res_id <= owner; res_last <= req_last[owner].
  - res_valid <= 1; carry <= cout; first <= 0.
- **Transaction end:** accepting a byte with req_last set returns the FSM to IDLE and sets rr <= ~owner.
- **Result slot:** res_valid clears on res_valid & res_ready when no accept happens in the same cycle. Accept and drain in the same cycle overwrite the slot, and res_valid stays 1.
- **Owner stalls:** if the owner drops req_valid mid-transaction, the grant is kept with no timeout. The carry register and mode hold.
- **Single-byte transaction:** a byte that is both first and last is legal.
- **Reset (any time, including mid-transaction):** FSM -> IDLE, rr = 0, owner = 0, carry = 0, mode = 0. All outputs go to 0: req_ready = 00, res_valid, res_sum, res_id, res_last, res_cout, busy. A partial transaction is discarded and produces no further results.
- **Arithmetic:** modulo 2^8 per byte. The carry is exactly the adder cout; there is no saturation and no overflow flag.

## Timing
- Grant latency: req_valid rising in IDLE gives req_ready high on the next cycle (given an empty slot).
- Accept-to-result: res_valid and its data appear one cycle after the accepting edge.
- Throughput: 1 byte/cycle while res_ready stays high.
- Inter-transaction gap: exactly one cycle (the IDLE grant cycle).
- Backpressure: with res_valid=1 and res_ready=0, req_ready=0 in the same cycle. The slot contents stay stable until drained.
- busy is 1 from the cycle after the grant through the cycle of the last-byte accept, and 0 in IDLE.

## Test plan
- **Reset:** assert rst with stimulus active -> all outputs 0 during reset and on the first cycle after. First grant goes to requester 0 when both request.
- **Requester 0 add, 0x01FF + 0x0001:** bytes (FF,01) then (01,00, last) -> results 0x00 (cout 1) then 0x02 (cout 0, last 1), res_id 0.
- **Requester 1 subtract, 0x0100 - 0x0001:** bytes (00,01) then (01,00, last) -> results 0xFF (cout 0) then 0x00 (cout 1, last 1). Separately, single-byte 0x00 - 0x01 -> 0xFF, cout 0, last 1.
- **Contention:** both requesters issue continuous 1-byte transactions -> grant order 0,1,0,1, with one idle cycle between each. res_id alternates accordingly.
- **Backpressure:** hold res_ready=0 for 3 cycles during a 3-byte transaction -> req_ready drops after one stored result, res_sum stays stable, no byte is lost or duplicated, and the carry is correct after release.
- **Mid-transaction reset:** pulse rst after byte 1 of a 3-byte add -> outputs go to 0 and no further results from that transaction appear. A new transaction afterwards starts with carry-in = 0.
